// File: rtl/linalg_pkg.sv
// Shared types and constants for the linear-algebra datapath blocks.
package linalg_pkg;

    localparam int unsigned FP32_W = 32;

    typedef enum logic [2:0] {
        StArbitrate,
        StGetOperands,
        StMulIn,
        StMulOut,
        StPutResult
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at ptr, ptr+1, ... modulo N_REQ.
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  winner,
    output logic             any
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    // Scan from ptr upward; ptr and offset are both below N_REQ, so one subtraction wraps.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        w_sum  = '0;
        w_idx  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            w_sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (w_sum >= (ID_W + 1)'(N_REQ)) begin
                w_sum = w_sum - (ID_W + 1)'(N_REQ);
            end
            w_idx = w_sum[ID_W-1:0];
            if (!any && req[w_idx]) begin
                any    = 1'b1;
                winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one stb/ack FP32 multiplier among N_REQ requesters,
// one operation in flight at a time.
module multiplier_arbiter
    import linalg_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0][FP32_W-1:0] req_a,
    input  logic [N_REQ-1:0][FP32_W-1:0] req_b,
    input  logic [N_REQ-1:0]             req_stb,
    output logic [N_REQ-1:0]             req_ack,
    output logic [N_REQ-1:0][FP32_W-1:0] resp_z,
    output logic [N_REQ-1:0]             resp_stb,
    input  logic [N_REQ-1:0]             resp_ack,
    output logic [FP32_W-1:0]            mul_input_a,
    output logic [FP32_W-1:0]            mul_input_b,
    output logic                         mul_input_a_stb,
    output logic                         mul_input_b_stb,
    input  logic                         mul_input_a_ack,
    input  logic                         mul_input_b_ack,
    input  logic [FP32_W-1:0]            mul_output_z,
    input  logic                         mul_output_z_stb,
    output logic                         mul_output_z_ack,
    output logic                         busy,
    output logic [ID_W-1:0]              grant_id
);

    arb_state_t                   r_state, w_state_d;
    logic [ID_W-1:0]              r_ptr, w_ptr_d;
    logic [ID_W-1:0]              r_grant, w_grant_d;
    logic [N_REQ-1:0]             r_req_ack, w_req_ack_d;
    logic [N_REQ-1:0][FP32_W-1:0] r_resp_z, w_resp_z_d;
    logic [N_REQ-1:0]             r_resp_stb, w_resp_stb_d;
    logic [FP32_W-1:0]            r_mul_a, w_mul_a_d;
    logic [FP32_W-1:0]            r_mul_b, w_mul_b_d;
    logic                         r_a_stb, w_a_stb_d;
    logic                         r_b_stb, w_b_stb_d;
    logic                         r_a_done, w_a_done_d;
    logic                         r_b_done, w_b_done_d;
    logic                         r_z_ack, w_z_ack_d;
    logic                         r_busy, w_busy_d;

    logic [ID_W-1:0] w_winner;
    logic            w_any;
    logic            w_a_fire;
    logic            w_b_fire;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req    (req_stb),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    assign w_a_fire = r_a_stb & mul_input_a_ack;
    assign w_b_fire = r_b_stb & mul_input_b_ack;

    // State register with synchronous active-low reset; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= StArbitrate;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_req_ack  <= '0;
            r_resp_z   <= '0;
            r_resp_stb <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_a_stb    <= 1'b0;
            r_b_stb    <= 1'b0;
            r_a_done   <= 1'b0;
            r_b_done   <= 1'b0;
            r_z_ack    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_ptr      <= w_ptr_d;
            r_grant    <= w_grant_d;
            r_req_ack  <= w_req_ack_d;
            r_resp_z   <= w_resp_z_d;
            r_resp_stb <= w_resp_stb_d;
            r_mul_a    <= w_mul_a_d;
            r_mul_b    <= w_mul_b_d;
            r_a_stb    <= w_a_stb_d;
            r_b_stb    <= w_b_stb_d;
            r_a_done   <= w_a_done_d;
            r_b_done   <= w_b_done_d;
            r_z_ack    <= w_z_ack_d;
            r_busy     <= w_busy_d;
        end
    end

    // Next-state logic for the five-phase transaction sequencer.
    always_comb begin
        w_state_d    = r_state;
        w_ptr_d      = r_ptr;
        w_grant_d    = r_grant;
        w_req_ack_d  = r_req_ack;
        w_resp_z_d   = r_resp_z;
        w_resp_stb_d = r_resp_stb;
        w_mul_a_d    = r_mul_a;
        w_mul_b_d    = r_mul_b;
        w_a_stb_d    = r_a_stb;
        w_b_stb_d    = r_b_stb;
        w_a_done_d   = r_a_done;
        w_b_done_d   = r_b_done;
        w_z_ack_d    = r_z_ack;

        unique case (r_state)
            StArbitrate: begin
                if (w_any) begin
                    w_grant_d             = w_winner;
                    w_req_ack_d[w_winner] = 1'b1;
                    w_state_d             = StGetOperands;
                end
            end
            StGetOperands: begin
                if (req_stb[r_grant] && r_req_ack[r_grant]) begin
                    w_mul_a_d            = req_a[r_grant];
                    w_mul_b_d            = req_b[r_grant];
                    w_req_ack_d[r_grant] = 1'b0;
                    w_a_stb_d            = 1'b1;
                    w_b_stb_d            = 1'b1;
                    w_state_d            = StMulIn;
                end
            end
            StMulIn: begin
                // Operand channels complete independently, in either order.
                if (w_a_fire) w_a_stb_d = 1'b0;
                if (w_b_fire) w_b_stb_d = 1'b0;
                w_a_done_d = r_a_done | w_a_fire;
                w_b_done_d = r_b_done | w_b_fire;
                if (w_a_done_d && w_b_done_d) begin
                    w_a_done_d = 1'b0;
                    w_b_done_d = 1'b0;
                    w_z_ack_d  = 1'b1;
                    w_state_d  = StMulOut;
                end
            end
            StMulOut: begin
                if (mul_output_z_stb && r_z_ack) begin
                    w_resp_z_d[r_grant]   = mul_output_z;
                    w_resp_stb_d[r_grant] = 1'b1;
                    w_z_ack_d             = 1'b0;
                    w_state_d             = StPutResult;
                end
            end
            StPutResult: begin
                if (r_resp_stb[r_grant] && resp_ack[r_grant]) begin
                    w_resp_stb_d[r_grant] = 1'b0;
                    // The requester just served drops to lowest priority.
                    w_ptr_d   = (r_grant == ID_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
                    w_state_d = StArbitrate;
                end
            end
            default: w_state_d = StArbitrate;
        endcase

        w_busy_d = (w_state_d != StArbitrate);
    end

    assign req_ack          = r_req_ack;
    assign resp_z           = r_resp_z;
    assign resp_stb         = r_resp_stb;
    assign mul_input_a      = r_mul_a;
    assign mul_input_b      = r_mul_b;
    assign mul_input_a_stb  = r_a_stb;
    assign mul_input_b_stb  = r_b_stb;
    assign mul_output_z_ack = r_z_ack;
    assign busy             = r_busy;
    assign grant_id         = r_grant;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed testbench for multiplier_arbiter with behavioural requester and multiplier models.
module tb_multiplier_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic                clk;
    logic                rst;
    logic [N-1:0][31:0]  req_a, req_b, resp_z;
    logic [N-1:0]        req_stb, req_ack, resp_stb, resp_ack;
    logic [31:0]         mul_input_a, mul_input_b, mul_output_z;
    logic                mul_input_a_stb, mul_input_b_stb, mul_input_a_ack, mul_input_b_ack;
    logic                mul_output_z_stb, mul_output_z_ack, busy;
    logic [IW-1:0]       grant_id;

    int          checks, failures, viol;
    int          a_delay, b_delay, z_delay, resp_delay;
    int          m_ops, a_xfers, b_xfers;
    int          got_cnt[N];
    logic [31:0] got_z[N];
    int          ack_cycles[N];
    int          resp_hi[N];
    int          rearm[N];
    int          grant_q[$];
    logic [31:0] a_op[N];
    logic [31:0] z_exp[N];

    multiplier_arbiter #(
        .N_REQ (N),
        .ID_W  (IW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_stb          (req_stb),
        .req_ack          (req_ack),
        .resp_z           (resp_z),
        .resp_stb         (resp_stb),
        .resp_ack         (resp_ack),
        .mul_input_a      (mul_input_a),
        .mul_input_b      (mul_input_b),
        .mul_input_a_stb  (mul_input_a_stb),
        .mul_input_b_stb  (mul_input_b_stb),
        .mul_input_a_ack  (mul_input_a_ack),
        .mul_input_b_ack  (mul_input_b_ack),
        .mul_output_z     (mul_output_z),
        .mul_output_z_stb (mul_output_z_stb),
        .mul_output_z_ack (mul_output_z_ack),
        .busy             (busy),
        .grant_id         (grant_id)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier: only the hand-computed operand pairs used below, order-sensitive.
    function automatic logic [31:0] fp_prod(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: fp_prod = 32'h40C00000; // 2*3
            {32'h3F800000, 32'h40000000}: fp_prod = 32'h40000000; // 1*2
            {32'h40000000, 32'h40000000}: fp_prod = 32'h40800000; // 2*2
            {32'h40400000, 32'h40000000}: fp_prod = 32'h40C00000; // 3*2
            {32'h40800000, 32'h40000000}: fp_prod = 32'h41000000; // 4*2
            default:                      fp_prod = 32'hDEADBEEF;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic clear_stats();
        grant_q.delete();
        m_ops = 0; a_xfers = 0; b_xfers = 0;
        for (int i = 0; i < N; i++) begin
            got_cnt[i] = 0; ack_cycles[i] = 0; resp_hi[i] = 0; rearm[i] = 0;
        end
    endtask

    task automatic wait_count(input int i, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            step();
            if (got_cnt[i] >= n) ok = 1'b1;
        end
    endtask

    // Multiplier model: acks operands after a_delay/b_delay, returns product after z_delay.
    task automatic mul_model();
        bit have_a, have_b, pa, pb, pz, xa, xb, xz;
        logic [31:0] cap_a, cap_b;
        int ca, cb, cz;
        have_a = 0; have_b = 0; pa = 0; pb = 0; pz = 0; ca = 0; cb = 0; cz = 0;
        cap_a = '0; cap_b = '0;
        forever begin
            step();
            if (!rst) begin
                mul_input_a_ack = 0; mul_input_b_ack = 0; mul_output_z_stb = 0;
                have_a = 0; have_b = 0; pa = 0; pb = 0; pz = 0; ca = 0; cb = 0; cz = 0;
            end else begin
                xa = mul_input_a_ack && pa;
                xb = mul_input_b_ack && pb;
                xz = mul_output_z_stb && pz;
                if (xa) begin if (have_a) viol++; have_a = 1; a_xfers++; mul_input_a_ack = 0; end
                if (xb) begin if (have_b) viol++; have_b = 1; b_xfers++; mul_input_b_ack = 0; end
                if (xz) begin mul_output_z_stb = 0; have_a = 0; have_b = 0; m_ops++; end
                if (pa && !xa && !mul_input_a_stb) viol++;
                if (pb && !xb && !mul_input_b_stb) viol++;
                if (pz && !xz && !mul_output_z_ack) viol++;
                if (have_a && mul_input_a_stb) viol++;
                if (have_b && mul_input_b_stb) viol++;
                if (mul_input_a_stb && !mul_input_a_ack && !have_a) begin
                    if (ca >= a_delay) begin mul_input_a_ack = 1; cap_a = mul_input_a; ca = 0; end
                    else ca++;
                end
                if (mul_input_b_stb && !mul_input_b_ack && !have_b) begin
                    if (cb >= b_delay) begin mul_input_b_ack = 1; cap_b = mul_input_b; cb = 0; end
                    else cb++;
                end
                if (have_a && have_b && !mul_output_z_stb) begin
                    if (cz >= z_delay) begin
                        mul_output_z = fp_prod(cap_a, cap_b); mul_output_z_stb = 1; cz = 0;
                    end else cz++;
                end
                pa = mul_input_a_stb; pb = mul_input_b_stb; pz = mul_output_z_ack;
            end
        end
    endtask

    // Requester model: drops req_stb on transfer, acks results after resp_delay.
    task automatic req_model();
        bit pack[N];
        bit pst[N];
        int rc[N];
        logic [31:0] rcap[N];
        bit xr, xs;
        for (int i = 0; i < N; i++) begin pack[i] = 0; pst[i] = 0; rc[i] = 0; rcap[i] = '0; end
        forever begin
            step();
            if (!rst) begin
                resp_ack = '0;
                for (int i = 0; i < N; i++) begin pack[i] = 0; pst[i] = 0; rc[i] = 0; end
            end else begin
                if ((|req_ack) && (|resp_stb)) viol++;
                if ($countones(req_ack) > 1) viol++;
                for (int i = 0; i < N; i++) begin
                    xr = pack[i] && req_stb[i];
                    xs = resp_ack[i] && pst[i];
                    if (xr) begin req_stb[i] = 0; grant_q.push_back(i); end
                    if (req_ack[i]) ack_cycles[i]++;
                    if (xs) begin
                        resp_ack[i] = 0; got_z[i] = rcap[i]; got_cnt[i]++;
                        if (rearm[i] > 0) begin rearm[i]--; req_stb[i] = 1; end
                    end
                    if (pst[i] && !xs && !resp_stb[i]) viol++;
                    if (resp_stb[i]) resp_hi[i]++;
                    if (resp_stb[i] && !resp_ack[i]) begin
                        if (rc[i] >= resp_delay) begin resp_ack[i] = 1; rcap[i] = resp_z[i]; rc[i] = 0; end
                        else rc[i]++;
                    end
                    pack[i] = req_ack[i]; pst[i] = resp_stb[i];
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++; if (req_ack !== '0 || resp_stb !== '0) begin failures++;
            $display("FAIL reset_acks: req_ack=%b resp_stb=%b want 0", req_ack, resp_stb); end
        checks++; if ({mul_input_a_stb, mul_input_b_stb, mul_output_z_ack} !== 3'b000) begin failures++;
            $display("FAIL reset_mul_stb: got %b want 000",
                     {mul_input_a_stb, mul_input_b_stb, mul_output_z_ack}); end
        checks++; if (busy !== 1'b0 || grant_id !== IW'(0)) begin failures++;
            $display("FAIL reset_busy_gid: busy=%b grant_id=%0d want 0/0", busy, grant_id); end
        checks++; if (mul_input_a !== 32'h0 || mul_input_b !== 32'h0 || resp_z !== '0) begin failures++;
            $display("FAIL reset_data: a=%h b=%h resp_z=%h want 0", mul_input_a, mul_input_b, resp_z); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        bit ok;
        clear_stats();
        a_delay = 0; b_delay = 0; z_delay = 1; resp_delay = 2;
        req_a[0] = 32'h40000000; req_b[0] = 32'h40400000; req_stb[0] = 1'b1;
        wait_count(0, 1, 60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_done: got timeout want response"); end
        checks++; if (got_z[0] !== 32'h40C00000) begin failures++;
            $display("FAIL single_z: got %h want 40c00000", got_z[0]); end
        checks++; if (ack_cycles[0] != 1) begin failures++;
            $display("FAIL single_ack_pulse: got %0d cycles want 1", ack_cycles[0]); end
        checks++; if (resp_hi[0] != 3) begin failures++;
            $display("FAIL single_resp_hold: got %0d cycles want 3", resp_hi[0]); end
        checks++; if (grant_q.size() != 1 || grant_q[0] != 0) begin failures++;
            $display("FAIL single_grant: got %p want '{0}", grant_q); end
        checks++; if (grant_id !== IW'(0)) begin failures++;
            $display("FAIL single_gid: got %0d want 0", grant_id); end
        step();
        checks++; if (busy !== 1'b0 || resp_z[0] !== 32'h40C00000) begin failures++;
            $display("FAIL single_after: busy=%b resp_z0=%h want 0/40c00000", busy, resp_z[0]); end
    endtask

    task automatic test_all_four();
        bit ok;
        int exp_ord[5];
        exp_ord = '{0, 1, 2, 3, 0};
        do_reset();
        clear_stats();
        z_delay = 2; resp_delay = 0;
        for (int i = 0; i < N; i++) begin req_a[i] = a_op[i]; req_b[i] = 32'h40000000; end
        rearm[0] = 1;
        req_stb = '1;
        wait_count(0, 2, 400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL all4_done: got timeout want 5 responses"); end
        checks++; if (grant_q.size() != 5) begin failures++;
            $display("FAIL all4_count: got %0d grants want 5", grant_q.size()); end
        for (int k = 0; k < 5 && k < grant_q.size(); k++) begin
            checks++; if (grant_q[k] != exp_ord[k]) begin failures++;
                $display("FAIL all4_order[%0d]: got %0d want %0d", k, grant_q[k], exp_ord[k]); end
        end
        for (int i = 0; i < N; i++) begin
            checks++; if (got_z[i] !== z_exp[i]) begin failures++;
                $display("FAIL all4_z[%0d]: got %h want %h", i, got_z[i], z_exp[i]); end
        end
        checks++; if (ack_cycles[0] != 2) begin failures++;
            $display("FAIL all4_ack0: got %0d want 2", ack_cycles[0]); end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_stats();
        req_stb[2] = 1'b1;
        wait_count(2, 1, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_prep: got timeout want response"); end
        clear_stats();
        req_stb[1] = 1'b1; req_stb[3] = 1'b1;
        wait_count(1, 1, 200, ok);
        checks++; if (!ok || grant_q.size() != 2 || grant_q[0] != 3 || grant_q[1] != 1) begin failures++;
            $display("FAIL wrap_order: got %p want '{3,1}", grant_q); end
        checks++; if (got_z[3] !== 32'h41000000 || got_z[1] !== 32'h40800000) begin failures++;
            $display("FAIL wrap_z: got %h/%h want 41000000/40800000", got_z[3], got_z[1]); end
        checks++; if (grant_id !== IW'(1)) begin failures++;
            $display("FAIL wrap_gid: got %0d want 1", grant_id); end
        clear_stats();
        req_stb[1] = 1'b1; req_stb[2] = 1'b1;
        wait_count(1, 1, 200, ok);
        checks++; if (!ok || grant_q.size() != 2 || grant_q[0] != 2 || grant_q[1] != 1) begin failures++;
            $display("FAIL wrap_ptr2: got %p want '{2,1}", grant_q); end
    endtask

    task automatic test_backpressure();
        bit ok, found;
        clear_stats();
        a_delay = 3; b_delay = 1; z_delay = 0; resp_delay = 5;
        req_stb[0] = 1'b1;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin step(); if (resp_stb[0]) found = 1; end
        checks++; if (!found) begin failures++; $display("FAIL bp_resp: got timeout want resp_stb[0]"); end
        req_stb[1] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (busy !== 1'b1 || grant_id !== IW'(0) || req_ack !== '0 || resp_stb[0] !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: busy=%b gid=%0d req_ack=%b resp_stb0=%b want 1/0/0000/1",
                         k, busy, grant_id, req_ack, resp_stb[0]);
            end
        end
        wait_count(1, 1, 200, ok);
        checks++; if (!ok || grant_q.size() != 2 || grant_q[0] != 0 || grant_q[1] != 1) begin failures++;
            $display("FAIL bp_order: got %p want '{0,1}", grant_q); end
        checks++; if (resp_hi[0] != 6) begin failures++;
            $display("FAIL bp_resp_hold: got %0d cycles want 6", resp_hi[0]); end
        checks++; if (got_z[0] !== 32'h40000000 || got_z[1] !== 32'h40800000) begin failures++;
            $display("FAIL bp_z: got %h/%h want 40000000/40800000", got_z[0], got_z[1]); end
        checks++; if (a_xfers != 2 || b_xfers != 2 || m_ops != 2) begin failures++;
            $display("FAIL bp_xfers: got a=%0d b=%0d z=%0d want 2/2/2", a_xfers, b_xfers, m_ops); end
        a_delay = 0; b_delay = 0; resp_delay = 0;
    endtask

    task automatic test_reset_mid();
        bit ok, found;
        clear_stats();
        z_delay = 8;
        req_stb[3] = 1'b1;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin step(); if (mul_output_z_ack) found = 1; end
        checks++; if (!found || grant_id !== IW'(3)) begin failures++;
            $display("FAIL rmid_reach: found=%b gid=%0d want 1/3", found, grant_id); end
        rst = 1'b0;
        step();
        checks++;
        if (req_ack !== '0 || resp_stb !== '0 || mul_input_a_stb !== 1'b0 || mul_input_b_stb !== 1'b0 ||
            mul_output_z_ack !== 1'b0 || busy !== 1'b0 || grant_id !== IW'(0)) begin
            failures++;
            $display("FAIL rmid_ctrl: req_ack=%b resp_stb=%b stb=%b%b zack=%b busy=%b gid=%0d want 0",
                     req_ack, resp_stb, mul_input_a_stb, mul_input_b_stb, mul_output_z_ack, busy, grant_id);
        end
        checks++; if (resp_z !== '0 || mul_input_a !== 32'h0 || mul_input_b !== 32'h0) begin failures++;
            $display("FAIL rmid_data: resp_z=%h a=%h b=%h want 0", resp_z, mul_input_a, mul_input_b); end
        step();
        rst = 1'b1;
        repeat (12) step();
        checks++; if (got_cnt[3] != 0) begin failures++;
            $display("FAIL rmid_noresp: got %0d responses want 0", got_cnt[3]); end
        clear_stats();
        z_delay = 1;
        req_stb[0] = 1'b1; req_stb[2] = 1'b1;
        wait_count(2, 1, 200, ok);
        checks++; if (!ok || grant_q.size() != 2 || grant_q[0] != 0 || grant_q[1] != 2) begin failures++;
            $display("FAIL rmid_ptr0: got %p want '{0,2}", grant_q); end
        checks++; if (got_z[0] !== 32'h40000000 || got_z[2] !== 32'h40C00000) begin failures++;
            $display("FAIL rmid_z: got %h/%h want 40000000/40c00000", got_z[0], got_z[2]); end
    endtask

    task automatic test_idle();
        clear_stats();
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (busy !== 1'b0 || mul_input_a_stb !== 1'b0 || mul_input_b_stb !== 1'b0 || req_ack !== '0) begin
                failures++;
                $display("FAIL idle[%0d]: busy=%b stb=%b%b req_ack=%b want 0", k, busy,
                         mul_input_a_stb, mul_input_b_stb, req_ack);
            end
        end
        checks++; if (viol != 0) begin failures++;
            $display("FAIL protocol: got %0d handshake violations want 0", viol); end
    endtask

    task automatic run_all();
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_idle();
    endtask

    initial begin
        clk = 0; rst = 0;
        req_a = '0; req_b = '0; req_stb = '0; resp_ack = '0;
        mul_input_a_ack = 0; mul_input_b_ack = 0; mul_output_z_stb = 0; mul_output_z = '0;
        checks = 0; failures = 0; viol = 0;
        a_delay = 0; b_delay = 0; z_delay = 0; resp_delay = 0;
        a_op[0] = 32'h3F800000; a_op[1] = 32'h40000000; a_op[2] = 32'h40400000; a_op[3] = 32'h40800000;
        z_exp[0] = 32'h40000000; z_exp[1] = 32'h40800000; z_exp[2] = 32'h40C00000; z_exp[3] = 32'h41000000;
        for (int i = 0; i < N; i++) got_z[i] = '0;
        clear_stats();
        fork
            mul_model();
            req_model();
            run_all();
            begin
                repeat (20000) @(posedge clk);
                failures++;
                $display("FAIL watchdog: got no completion want tests to finish");
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiplier_arbiter.md
Name: multiplier_arbiter

Overview:
- Shares one single-precision `multiplier` core (stb/ack handshake, IEEE-754 binary32) among N_REQ independent requesters.
- Round-robin fair, one operation in flight at a time.
- Lets several small linear-algebra blocks, such as scalar/vector/matrix multiply units, time-share a multiplier instead of each instantiating their own.
- Sits between requesters and a single `multiplier` instance; the arbiter exposes the multiplier-side ports and the parent instantiates the core.

Parameters:
- N_REQ, 4, number of requesters (>=1).
- ID_W, $clog2(N_REQ) with minimum 1, width of grant_id.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset; state is cleared on any rising edge where rst==0.
- req_a  input  [N_REQ-1:0][31:0]  operand a per requester.
- req_b  input  [N_REQ-1:0][31:0]  operand b per requester.
- req_stb  input  N_REQ  operand pair valid; held until req_ack.
- req_ack  output  N_REQ  operand pair accepted.
- resp_z  output  [N_REQ-1:0][31:0]  product per requester.
- resp_stb  output  N_REQ  product valid.
- resp_ack  input  N_REQ  product consumed.
- mul_input_a / mul_input_b  output  32  operands to multiplier.
- mul_input_a_stb / mul_input_b_stb  output  1  operand strobes.
- mul_input_a_ack / mul_input_b_ack  input  1  multiplier operand acks.
- mul_output_z  input  32  multiplier result.
- mul_output_z_stb  input  1  result valid.
- mul_output_z_ack  output  1  result accepted.
- busy  output  1  high in any state other than ARBITRATE.
- grant_id  output  ID_W  index of the current or last granted requester.

Behaviour:
- Handshake rule on every channel: a transfer occurs on a cycle where stb and ack are both high. Producers hold stb and data stable until that transfer. All outputs are registered.
- Reset (rst==0): every output stb/ack is 0, resp_z is 0, mul_input_a/b are 0, busy=0, grant_id=0, round-robin pointer ptr=0, state=ARBITRATE. Reset mid-operation abandons the transaction with no response; the multiplier shares the same rst.
- FSM states: ARBITRATE, GET_OPERANDS, MUL_IN, MUL_OUT, PUT_RESULT.
- ARBITRATE:
  - If no req_stb is set, hold.
  - Otherwise the winner is the first set req_stb at index ptr, ptr+1, ... wrapping modulo N_REQ.
  - Register grant_id<=winner and req_ack[winner]<=1, then go to GET_OPERANDS.
- GET_OPERANDS:
  - On req_stb[g]&&req_ack[g]: latch mul_input_a<=req_a[g] and mul_input_b<=req_b[g], set req_ack[g]<=0 and both mul_input_*_stb<=1, go to MUL_IN.
  - Under protocol this happens on the first cycle, so req_ack is high for exactly one cycle.
- MUL_IN:
  - a_stb and b_stb drop independently on their own ack.
  - Track a_done/b_done; when both are done, clear them, set mul_output_z_ack<=1, go to MUL_OUT.
  - Acks arriving in the same cycle or in different cycles are both legal.
- MUL_OUT:
  - On mul_output_z_stb&&mul_output_z_ack: resp_z[g]<=mul_output_z, mul_output_z_ack<=0, resp_stb[g]<=1, go to PUT_RESULT.
- PUT_RESULT:
  - On resp_stb[g]&&resp_ack[g]: resp_stb[g]<=0, ptr<=(g+1) mod N_REQ, go to ARBITRATE.
  - resp_z[g] keeps its value until overwritten by that requester's next grant.
- Fairness: a requester that holds req_stb waits at most N_REQ-1 other transactions.
- Boundary cases:
  - N_REQ=1 degenerates to a pass-through sequencer with ptr fixed at 0.
  - g == N_REQ-1 wraps ptr to 0.
  - A new req_stb arriving during a transaction is only sampled in ARBITRATE.
  - The current requester re-raising req_stb immediately after its response gets lowest priority.
- Overhead: 4 cycles in addition to multiplier latency (ARBITRATE, GET_OPERANDS, the state edges into MUL_OUT, and PUT_RESULT with an immediate ack).

Decomposition:
- Package linalg_pkg: FP32 width constant (32) and arb_state_t enum for the five states.
- Sub-module rr_picker: purely combinational, with inputs req[N_REQ] and ptr, outputs winner and any. Kept separate so it can be reused by the vector/matrix schedulers.

Test Plan:
- Single request: req_stb[0] with a=0x40000000 (2.0), b=0x40400000 (3.0) -> req_ack[0] pulses for one cycle, resp_z[0]=0x40C00000 (6.0), resp_stb[0] held until resp_ack, grant_id=0.
- All four requesting simultaneously after reset, with operands i+1.0 times 2.0 -> grants in order 0,1,2,3 and each resp_z is correct. Requester 0 re-requesting immediately is served after 3.
- Wrap: ptr=3 with requests on 1 and 3 -> 3 is granted first, then 1; ptr after 1 is 2.
- Backpressure: multiplier acks b two cycles before a, resp_ack delayed 5 cycles -> stb levels hold, no duplicate transfers, no new grant until resp_ack.
- Reset (rst=0) asserted in MUL_OUT -> the next cycle has all stb/ack=0, busy=0, ptr=0. A request after rst returns high completes normally.
- Idle: no req_stb for 20 cycles -> busy=0 and no multiplier strobes.
